// File: rtl/stall_timer_pkg.sv
// stall_pkg: shared defaults, channel indices and retrigger-mode encodings for the stall timer
package stall_pkg;
  localparam int NCH_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int STAT_W_DEF = 16;
  localparam int CH_MEM = 0;
  localparam int CH_MUL = 1;
  localparam int CH_BR = 2;
  localparam int CH_EXT = 3;
  localparam int MERGE_RESTART = 0;
  localparam int MERGE_MAX = 1;
endpackage

// File: rtl/stall_timer_if.sv
// stall_timer_if: request/status bundle between the control decoder and the stall timer
interface stall_timer_if
  import stall_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
);
  logic [NCH-1:0] req;
  logic [NCH*CNT_W-1:0] delay;
  logic flush;
  logic pc_en;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic [STAT_W-1:0] stall_cnt;
  modport master (output req, delay, flush, input pc_en, busy, done, stall_cnt);
  modport slave (input req, delay, flush, output pc_en, busy, done, stall_cnt);
endinterface

// File: rtl/stall_timer_chan.sv
// stall_chan: one stall channel with request edge detect, delay counter and busy/done flags
module stall_chan
  import stall_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int MERGE = MERGE_RESTART
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic flush,
  input  logic [CNT_W-1:0] delay,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic reqQ;
  logic rise;
  logic trig;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntDec;
  logic [CNT_W-1:0] loadVal;
  logic [CNT_W-1:0] cntNext;
  // cnt holds remaining busy cycles after this one, so a trigger loads D-1 and busy covers the rise cycle
  always_comb begin
    rise = req & ~reqQ;
    trig = rise & (delay != '0) & ~flush;
    cntDec = (cnt != '0) ? cnt - ONE : '0;
    loadVal = (MERGE == MERGE_MAX && cntDec > delay - ONE) ? cntDec : delay - ONE;
    cntNext = flush ? '0 : trig ? loadVal : cntDec;
    busy = (cnt != '0) | trig;
    done = busy & (cntNext == '0) & ~flush;
  end
  // state update; req history tracks req even while flushing so a held request cannot retrigger afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      reqQ <= 1'b0;
    end else begin
      cnt <= cntNext;
      reqQ <= req;
    end
  end
endmodule

// File: rtl/stall_timer.sv
// stall_timer: multi-channel PC stall timer with PC enable and saturating stall-cycle statistic
module stall_timer
  import stall_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int MERGE = MERGE_RESTART,
  parameter int STAT_W = STAT_W_DEF
) (
  input logic clk,
  input logic rst_n,
  stall_timer_if.slave bus
);
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic pcEn;
  logic [STAT_W-1:0] stallCnt;
  for (genvar i = 0; i < NCH; i++) begin : gChan
    stall_chan #(.CNT_W(CNT_W), .MERGE(MERGE)) uChan (
      .clk(clk),
      .rst_n(rst_n),
      .req(bus.req[i]),
      .flush(bus.flush),
      .delay(bus.delay[i*CNT_W +: CNT_W]),
      .busy(busy[i]),
      .done(done[i])
    );
  end
  assign pcEn = ~|busy;
  assign bus.pc_en = pcEn;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.stall_cnt = stallCnt;
  // count stalled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) stallCnt <= '0;
    else if (!pcEn && !(&stallCnt)) stallCnt <= stallCnt + STAT_W'(1);
  end
endmodule

// File: tb/tb_stall_timer.sv
// tb_stall_timer: scoreboard bench driving a restart-mode and a max-mode stall timer in parallel
module tb_stall_timer;
  import stall_pkg::*;
  localparam int NCH = 4;
  localparam int CW = 4;
  localparam int SW = 6;
  localparam int PCEN = 0;
  localparam int BUSY = 1;
  localparam int STAT = 2;
  typedef struct {int cyc; int dut; int kind; int val;} exp_t;
  typedef struct {int cyc; int ch; int dut;} done_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH*CW-1:0] dly = '0;
  logic flush = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t expQ[$];
  done_t doneQ[$];
  stall_timer_if #(.NCH(NCH), .CNT_W(CW), .STAT_W(SW)) b0();
  stall_timer_if #(.NCH(NCH), .CNT_W(CW), .STAT_W(SW)) b1();
  assign b0.req = req;
  assign b0.delay = dly;
  assign b0.flush = flush;
  assign b1.req = req;
  assign b1.delay = dly;
  assign b1.flush = flush;
  stall_timer #(.NCH(NCH), .CNT_W(CW), .MERGE(MERGE_RESTART), .STAT_W(SW)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  stall_timer #(.NCH(NCH), .CNT_W(CW), .MERGE(MERGE_MAX), .STAT_W(SW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int act(int d, int k);
    if (d == 0) return k == PCEN ? int'(b0.pc_en) : k == BUSY ? int'(b0.busy) : int'(b0.stall_cnt);
    return k == PCEN ? int'(b1.pc_en) : k == BUSY ? int'(b1.busy) : int'(b1.stall_cnt);
  endfunction
  function automatic string kname(int k);
    return k == PCEN ? "pc_en" : k == BUSY ? "busy" : "stall_cnt";
  endfunction
  task automatic ex(int c, int d, int k, int v);
    expQ.push_back('{c, d, k, v});
  endtask
  task automatic exd(int c, int ch, int d);
    if (d != 1) doneQ.push_back('{c, ch, 0});
    if (d != 0) doneQ.push_back('{c, ch, 1});
  endtask
  task automatic setD(int ch, int v);
    dly[ch*CW +: CW] = CW'(v);
  endtask
  task automatic waitCyc(int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic doneMon(int d, logic [NCH-1:0] dn);
    for (int ch = 0; ch < NCH; ch++) begin
      if (dn[ch]) begin
        int idx;
        idx = -1;
        for (int j = 0; j < doneQ.size(); j++) if (idx < 0 && doneQ[j].dut == d) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL done dut%0d: got pulse ch%0d at cyc %0d, want none", d, ch, cyc);
        end else begin
          if (doneQ[idx].cyc != cyc || doneQ[idx].ch != ch) begin
            errors++;
            $display("FAIL done dut%0d: got ch%0d at cyc %0d, want ch%0d at cyc %0d", d, ch, cyc, doneQ[idx].ch, doneQ[idx].cyc);
          end
          doneQ.delete(idx);
        end
      end
    end
  endtask
  // monitor: compare scheduled snapshots for this cycle and every done pulse against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int a;
    while (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
      e = expQ.pop_front();
      for (int d = 0; d < 2; d++) begin
        if (e.dut == 2 || e.dut == d) begin
          a = act(d, e.kind);
          checks++;
          if (e.cyc != cyc || a != e.val) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, want %0d (due cyc %0d)", kname(e.kind), d, cyc, a, e.val, e.cyc);
          end
        end
      end
    end
    doneMon(0, b0.done);
    doneMon(1, b1.done);
  end
  initial begin
    ex(1, 2, BUSY, 0); ex(3, 2, PCEN, 1); ex(3, 2, BUSY, 0); ex(3, 2, STAT, 0);
    waitCyc(2);
    rst_n = 1'b1;
    ex(10, 2, BUSY, 1); ex(10, 2, PCEN, 0); ex(14, 2, BUSY, 1); ex(15, 2, BUSY, 0);
    ex(15, 2, PCEN, 1); ex(15, 2, STAT, 5); ex(16, 2, BUSY, 1); ex(17, 2, BUSY, 0);
    ex(17, 2, STAT, 6); ex(18, 2, BUSY, 0); ex(18, 2, PCEN, 1); ex(19, 2, STAT, 6);
    exd(14, 0, 2); exd(16, 0, 2);
    setD(0, 5); waitCyc(10); req[0] = 1'b1; waitCyc(11); req[0] = 1'b0;
    setD(0, 1); waitCyc(16); req[0] = 1'b1; waitCyc(17); req[0] = 1'b0;
    setD(0, 0); waitCyc(18); req[0] = 1'b1; waitCyc(19); req[0] = 1'b0;
    ex(20, 2, BUSY, 5); ex(22, 2, BUSY, 5); ex(23, 2, BUSY, 4); ex(26, 2, PCEN, 0);
    ex(27, 2, PCEN, 1); ex(27, 2, STAT, 13);
    exd(22, 0, 2); exd(26, 2, 2);
    setD(0, 3); setD(2, 7); waitCyc(20); req = 4'b0101; waitCyc(21); req = 4'b0000;
    ex(32, 2, BUSY, 2); ex(33, 2, BUSY, 2); ex(34, 0, BUSY, 0); ex(34, 1, BUSY, 2);
    ex(35, 1, BUSY, 2); ex(36, 1, BUSY, 0); ex(37, 0, STAT, 17); ex(37, 1, STAT, 19);
    exd(33, 1, 0); exd(35, 1, 1);
    setD(1, 6); waitCyc(30); req[1] = 1'b1; waitCyc(31); req[1] = 1'b0;
    setD(1, 2); waitCyc(32); req[1] = 1'b1; waitCyc(33); req[1] = 1'b0;
    ex(40, 2, BUSY, 8); ex(42, 2, BUSY, 8); ex(42, 2, PCEN, 0); ex(43, 2, PCEN, 1);
    ex(43, 2, BUSY, 0); ex(44, 0, STAT, 20); ex(44, 1, STAT, 22); ex(45, 2, BUSY, 0);
    setD(3, 10); setD(0, 4); waitCyc(40); req[3] = 1'b1;
    waitCyc(42); flush = 1'b1; req[0] = 1'b1;
    waitCyc(43); flush = 1'b0;
    waitCyc(44); req[0] = 1'b0; req[3] = 1'b0;
    ex(53, 2, BUSY, 2); ex(54, 2, BUSY, 2); ex(54, 2, STAT, 0); ex(61, 2, BUSY, 2);
    ex(62, 2, BUSY, 0); ex(62, 2, PCEN, 1); ex(62, 2, STAT, 8);
    exd(61, 1, 2);
    setD(1, 8); waitCyc(50); req[1] = 1'b1;
    waitCyc(53); rst_n = 1'b0; waitCyc(54); rst_n = 1'b1;
    waitCyc(62); req[1] = 1'b0;
    ex(112, 2, STAT, 53); ex(145, 2, STAT, 63); ex(145, 2, PCEN, 1);
    for (int k = 0; k < 5; k++) exd(78 + 16 * k, 3, 2);
    setD(3, 15);
    for (int k = 0; k < 5; k++) begin
      waitCyc(64 + 16 * k); req[3] = 1'b1;
      waitCyc(65 + 16 * k); req[3] = 1'b0;
    end
    waitCyc(147);
    while (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked: want %0d at cyc %0d", kname(expQ[0].kind), expQ[0].val, expQ[0].cyc);
      void'(expQ.pop_front());
    end
    while (doneQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done dut%0d: got no pulse, want ch%0d at cyc %0d", doneQ[0].dut, doneQ[0].ch, doneQ[0].cyc);
      void'(doneQ.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
